cmos_pll_ctrl: RTL and testbench

- Sequencer and lock supervisor for the camera-clock PLL, running on the 50 MHz board clock.
- Drives the PLL's `reset` input and consumes its `lock` output: it is the controlling end of the PLL reset/lock interface.
- After a lock is filtered as stable, it declares the camera clock usable. On lock loss or timeout it re-runs the reset sequence.
- `clk_ready` gates the camera capture logic, and the CMOS sensor's reset release is derived from it.

---
 rtl/cmos_pll_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_cmos_pll_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cmos_pll_ctrl.sv
// cmos_pll_ctrl: reset sequencer and lock supervisor for the camera-clock PLL.
//
// The block pulses the PLL reset, waits for lock, and filters the lock until it
// has been stable for a while. It then declares the camera clock usable. If
// lock is lost, or never arrives within the timeout, it re-runs the reset
// sequence.
//
// Ports:
//   clkin      in   50 MHz board clock (only clock)
//   reset      in   asynchronous, active-high reset
//   pll_lock   in   PLL lock, asynchronous to clkin (synchronized here)
//   restart    in   one-cycle synchronous request to re-run the sequence
//   pll_reset  out  drives PLL reset, active high
//   clk_ready  out  PLL output valid and stable; gates camera capture
//   lock_lost  out  one-cycle pulse on loss of lock while running
//   lock_fail  out  sticky failure flag
//   retry_cnt  out  lock timeouts since last reset/restart, saturates at 15
//
// Build option:
//   PLL_CTRL_FAIL_LATCH_EN - when defined, the timeout that brings retry_cnt to
//   MAX_RETRY parks the block in FAIL (PLL held in reset, lock_fail set) until
//   reset or restart. When undefined, retries continue forever and lock_fail
//   is tied low.
module cmos_pll_ctrl #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int LOCK_STABLE  = 1024,
    parameter int MAX_RETRY    = 7
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       restart,
    output logic       pll_reset,
    output logic       clk_ready,
    output logic       lock_lost,
    output logic       lock_fail,
    output logic [3:0] retry_cnt
);

    // One shared counter, wide enough for the longest interval.
    localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_C = (MAX_A > LOCK_STABLE) ? MAX_A : LOCK_STABLE;
    localparam int CW    = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE - 1);

    typedef enum logic [2:0] {
        S_RST_PLL,
        S_WAIT_LOCK,
        S_STABLE,
`ifdef PLL_CTRL_FAIL_LATCH_EN
        S_FAIL,
`endif
        S_RUN
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      retry_q, retry_d;
    logic [3:0]      retry_inc;
    logic            lost_d;
    logic            sync1_q, lock_s_q;
    logic            pll_reset_q, clk_ready_q, lock_lost_q;
    logic            hold_rst_d;

    // Two-flop synchronizer; lock_s_q is the only lock view used below.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            sync1_q  <= pll_lock;
            lock_s_q <= sync1_q;
        end
    end

    assign retry_inc = (retry_q == 4'hF) ? 4'hF : retry_q + 4'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        retry_d = retry_q;
        lost_d  = 1'b0;
        // restart wins over everything, including a lock loss in RUN.
        if (restart) begin
            state_d = S_RST_PLL;
            cnt_d   = '0;
            retry_d = 4'd0;
        end else begin
            case (state_q)
                S_RST_PLL: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s_q) begin
                        state_d = S_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TO_LAST) begin
                        state_d = S_RST_PLL;
                        cnt_d   = '0;
                        retry_d = retry_inc;
`ifdef PLL_CTRL_FAIL_LATCH_EN
                        // Compare the unsaturated increment so a saturated
                        // counter cannot re-trigger the latch.
                        if (({1'b0, retry_q} + 5'd1) == 5'(MAX_RETRY))
                            state_d = S_FAIL;
`endif
                    end
                end
                S_STABLE: begin
                    // Any drop restarts the stability window without a retry.
                    if (!lock_s_q) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STB_LAST) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end
                end
                S_RUN: begin
                    cnt_d = '0;
                    if (!lock_s_q) begin
                        state_d = S_RST_PLL;
                        lost_d  = 1'b1;
                    end
                end
`ifdef PLL_CTRL_FAIL_LATCH_EN
                S_FAIL: cnt_d = '0;
`endif
                default: begin
                    state_d = S_RST_PLL;
                    cnt_d   = '0;
                end
            endcase
        end
    end

`ifdef PLL_CTRL_FAIL_LATCH_EN
    assign hold_rst_d = (state_d == S_RST_PLL) || (state_d == S_FAIL);
`else
    assign hold_rst_d = (state_d == S_RST_PLL);
`endif

    // Outputs are registered and decoded from the next state, so they change
    // on the same edge as the state.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_q     <= S_RST_PLL;
            cnt_q       <= '0;
            retry_q     <= 4'd0;
            pll_reset_q <= 1'b1;
            clk_ready_q <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_reset_q <= hold_rst_d;
            clk_ready_q <= (state_d == S_RUN);
            lock_lost_q <= lost_d;
        end
    end

`ifdef PLL_CTRL_FAIL_LATCH_EN
    logic lock_fail_q;
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) lock_fail_q <= 1'b0;
        else       lock_fail_q <= (state_d == S_FAIL);
    end
    assign lock_fail = lock_fail_q;
`else
    assign lock_fail = 1'b0;
`endif

    assign pll_reset = pll_reset_q;
    assign clk_ready = clk_ready_q;
    assign lock_lost = lock_lost_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_cmos_pll_ctrl.sv
// Self-checking bench for cmos_pll_ctrl. A timestamp-based reference model
// (edge count since entering each phase, lock seen two edges late) predicts
// every output each cycle; directed scenarios add exact-timing checks.
module tb_cmos_pll_ctrl;
    localparam int RC = 4;
    localparam int TO = 16;
    localparam int LS = 8;
    localparam int MR = 3;
`ifdef PLL_CTRL_FAIL_LATCH_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    logic       clkin = 1'b0;
    logic       reset, pll_lock, restart;
    logic       pll_reset, clk_ready, lock_lost, lock_fail;
    logic [3:0] retry_cnt;

    always #10 clkin = ~clkin;

    cmos_pll_ctrl #(
        .RST_CYCLES(RC), .LOCK_TIMEOUT(TO), .LOCK_STABLE(LS), .MAX_RETRY(MR)
    ) dut (
        .clkin(clkin), .reset(reset), .pll_lock(pll_lock), .restart(restart),
        .pll_reset(pll_reset), .clk_ready(clk_ready), .lock_lost(lock_lost),
        .lock_fail(lock_fail), .retry_cnt(retry_cnt)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum logic [2:0] {M_RST, M_WAIT, M_STAB, M_RUN, M_FAIL} mode_t;
    typedef struct packed {
        mode_t mode;
        int    e;      // edges since reset release
        int    t0;     // edge at which the current phase began
        logic  h1;     // pll_lock sampled one edge ago
        logic  h2;     // pll_lock sampled two edges ago
        logic  lost;
        int    retry;
    } ms_t;

    ms_t ms;

    function automatic ms_t mstep(ms_t s, logic lk, logic rs);
        ms_t  n;
        logic seen;
        n      = s;
        n.e    = s.e + 1;
        seen   = s.h2;
        n.h2   = s.h1;
        n.h1   = lk;
        n.lost = 1'b0;
        if (rs) begin
            n.mode  = M_RST;
            n.t0    = n.e;
            n.retry = 0;
        end else begin
            case (s.mode)
                M_RST: if (n.e - s.t0 == RC) begin n.mode = M_WAIT; n.t0 = n.e; end
                M_WAIT: begin
                    if (seen) begin
                        n.mode = M_STAB; n.t0 = n.e;
                    end else if (n.e - s.t0 == TO) begin
                        n.retry = (s.retry < 15) ? s.retry + 1 : 15;
                        n.t0    = n.e;
                        n.mode  = (FL && n.retry == MR) ? M_FAIL : M_RST;
                    end
                end
                M_STAB: begin
                    if (!seen) begin n.mode = M_WAIT; n.t0 = n.e; end
                    else if (n.e - s.t0 == LS) begin n.mode = M_RUN; n.t0 = n.e; end
                end
                M_RUN: if (!seen) begin n.mode = M_RST; n.t0 = n.e; n.lost = 1'b1; end
                default: ;
            endcase
        end
        return n;
    endfunction

    always @(posedge clkin or posedge reset) begin
        if (reset) ms <= '0;
        else       ms <= mstep(ms, pll_lock, restart);
    end

    logic [7:0] exp_v, got_v;
    assign exp_v = {(ms.mode == M_RST) || (ms.mode == M_FAIL), ms.mode == M_RUN,
                    ms.lost, ms.mode == M_FAIL, ms.retry[3:0]};
    assign got_v = {pll_reset, clk_ready, lock_lost, lock_fail, retry_cnt};

    // One clock: wait for the falling edge and compare against the model.
    task automatic step();
        @(negedge clkin);
        chk("outs", {24'b0, got_v}, {24'b0, exp_v});
    endtask

    task automatic wait_run(input string tag);
        for (int i = 0; i < 200 && !clk_ready; i++) step();
        chk(tag, {31'b0, clk_ready}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int lvl, len, r;
        reset = 1'b1; pll_lock = 1'b0; restart = 1'b0;
        #25;
        chk("rst_pll_reset", {31'b0, pll_reset}, 32'd1);
        chk("rst_clk_ready", {31'b0, clk_ready}, 32'd0);
        chk("rst_lock_lost", {31'b0, lock_lost}, 32'd0);
        chk("rst_lock_fail", {31'b0, lock_fail}, 32'd0);
        chk("rst_retry",     {28'b0, retry_cnt}, 32'd0);
        @(negedge clkin);
        reset = 1'b0;

        // Clean lock: lock first sampled at edge 5, ready at edge 15.
        for (int s = 1; s <= 20; s++) begin
            step();
            if (s == 3)  chk("clean_prst_hi", {31'b0, pll_reset}, 32'd1);
            if (s == 4)  begin chk("clean_prst_lo", {31'b0, pll_reset}, 32'd0); pll_lock = 1'b1; end
            if (s == 14) chk("clean_rdy_early", {31'b0, clk_ready}, 32'd0);
            if (s == 15) begin
                chk("clean_rdy", {31'b0, clk_ready}, 32'd1);
                chk("clean_retry", {28'b0, retry_cnt}, 32'd0);
            end
        end

        // Lock loss in RUN: 4-cycle drop.
        pll_lock = 1'b0;
        for (int s = 1; s <= 16; s++) begin
            step();
            if (s == 2) chk("loss_rdy_hold", {31'b0, clk_ready}, 32'd1);
            if (s == 3) begin
                chk("loss_rdy_fall", {31'b0, clk_ready}, 32'd0);
                chk("loss_pulse",    {31'b0, lock_lost}, 32'd1);
                chk("loss_prst",     {31'b0, pll_reset}, 32'd1);
            end
            if (s == 4) begin chk("loss_pulse_end", {31'b0, lock_lost}, 32'd0); pll_lock = 1'b1; end
            if (s == 6)  chk("loss_prst_hold", {31'b0, pll_reset}, 32'd1);
            if (s == 7)  chk("loss_prst_end",  {31'b0, pll_reset}, 32'd0);
            if (s == 15) chk("relock_early",   {31'b0, clk_ready}, 32'd0);
            if (s == 16) chk("relock_rdy",     {31'b0, clk_ready}, 32'd1);
        end

        // Stability filter: high 6, low 3, then high.
        pll_lock = 1'b0; restart = 1'b1;
        step();
        restart = 1'b0;
        chk("rs_prst", {31'b0, pll_reset}, 32'd1);
        repeat (4) step();
        pll_lock = 1'b1;
        first = 0;
        for (int s = 1; s <= 30; s++) begin
            step();
            if (clk_ready && first == 0) first = s;
            if (s == 6) pll_lock = 1'b0;
            if (s == 9) pll_lock = 1'b1;
        end
        chk("filter_rdy_edge", first, 20);
        chk("filter_retry", {28'b0, retry_cnt}, 32'd0);

        // Restart in the same cycle lock_s falls in RUN.
        pll_lock = 1'b0;
        step(); step();
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("sim_no_lost", {31'b0, lock_lost}, 32'd0);
        chk("sim_prst",    {31'b0, pll_reset}, 32'd1);
        chk("sim_rdy",     {31'b0, clk_ready}, 32'd0);
        chk("sim_retry",   {28'b0, retry_cnt}, 32'd0);
        pll_lock = 1'b1;
        wait_run("sim_relock");

        // Async reset while in STABLE.
        restart = 1'b1;
        step();
        restart = 1'b0;
        repeat (6) step();
        chk("stab_prst_lo", {31'b0, pll_reset}, 32'd0);
        #3 reset = 1'b1;
        #1 chk("async_prst", {31'b0, pll_reset}, 32'd1);
        step();
        reset = 1'b0;
        wait_run("after_reset_run");

        // Timeouts with lock held low.
        pll_lock = 1'b0; restart = 1'b1;
        step();
        restart = 1'b0;
        for (int j = 1; j <= 17; j++) begin
            repeat (20) step();
            chk("to_retry", {28'b0, retry_cnt},
                FL ? ((j < MR) ? j : MR) : ((j < 15) ? j : 15));
            chk("to_fail", {31'b0, lock_fail}, (FL && j >= MR) ? 32'd1 : 32'd0);
        end
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("to_rs_retry", {28'b0, retry_cnt}, 32'd0);
        chk("to_rs_fail",  {31'b0, lock_fail}, 32'd0);
        chk("to_rs_prst",  {31'b0, pll_reset}, 32'd1);

        // Randomized lock runs with occasional restart and reset.
        for (int it = 0; it < 150; it++) begin
            lvl = $urandom_range(0, 1);
            len = $urandom_range(1, 40);
            pll_lock = lvl[0];
            for (int t = 0; t < len; t++) begin
                r = $urandom_range(0, 99);
                if (r < 2) restart = 1'b1;
                if (r == 2) reset = 1'b1;
                step();
                restart = 1'b0;
                reset = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
